// File: rtl/std_rr_arbiter.sv
// -----------------------------------------------------------------------------
// std_rr_arbiter
//
// Round-robin arbiter for ENTRIES requesters. It drives a one-hot grant and a
// binary grant index, both suitable as the select of a one-hot or binary mux.
// A registered priority pointer rotates past each acknowledged winner. With
// KEEP_RESULT = 1 the first valid grant is frozen in flops until i_ack, so the
// mux selection cannot move while the consumer is still working on it.
//
// Ports:
//   i_clk          clock
//   i_rst          asynchronous, active-high reset
//   i_clear        synchronous clear of the pointer and the hold state
//   i_request      one request bit per entry
//   i_ack          the granted transfer completed this cycle
//   o_valid        the grant is meaningful
//   o_grant        one-hot grant, all-zero when o_valid = 0
//   o_grant_index  binary index of the granted entry, 0 when o_valid = 0
// -----------------------------------------------------------------------------
module std_rr_arbiter #(
    parameter int ENTRIES     = 2,
    parameter int KEEP_RESULT = 1,
    localparam int INDEX_WIDTH = (ENTRIES <= 1) ? 1 : $clog2(ENTRIES)
) (
    input  logic                   i_clk,
    input  logic                   i_rst,
    input  logic                   i_clear,
    input  logic [ENTRIES-1:0]     i_request,
    input  logic                   i_ack,
    output logic                   o_valid,
    output logic [ENTRIES-1:0]     o_grant,
    output logic [INDEX_WIDTH-1:0] o_grant_index
);

    // Priority pointer and grant-hold state.
    logic [INDEX_WIDTH-1:0] r_ptr;
    logic                   r_held;
    logic [ENTRIES-1:0]     r_held_grant;
    logic [INDEX_WIDTH-1:0] r_held_index;

    // Combinational arbitration result and the selection actually presented.
    logic                   w_any;
    logic [INDEX_WIDTH-1:0] w_arb_index;
    logic [ENTRIES-1:0]     w_arb_grant;
    logic                   w_valid;
    logic [INDEX_WIDTH-1:0] w_sel_index;
    logic [ENTRIES-1:0]     w_sel_grant;
    logic [INDEX_WIDTH-1:0] w_next_ptr;

    // The rotating scan ptr, ptr+1, ... wrapping at ENTRIES is split into two
    // plain priority searches: the lowest requester at or above ptr wins; if
    // there is none, the lowest requester overall wins (the wrapped part).
    // Scanning from the top down and overwriting leaves the lowest match.
    always_comb begin : arb_scan
        logic                   v_hi_found;
        logic                   v_lo_found;
        logic [INDEX_WIDTH-1:0] v_hi;
        logic [INDEX_WIDTH-1:0] v_lo;
        // NOTE: every variable gets a value before any conditional code, so
        // no path through this block can leave one unassigned and infer a latch.
        v_hi_found = 1'b0;
        v_lo_found = 1'b0;
        v_hi       = '0;
        v_lo       = '0;
        for (int i = ENTRIES - 1; i >= 0; i--) begin
            if (i_request[i]) begin
                v_lo_found = 1'b1;
                v_lo       = INDEX_WIDTH'(i);
                if (i >= int'(r_ptr)) begin
                    v_hi_found = 1'b1;
                    v_hi       = INDEX_WIDTH'(i);
                end
            end
        end
        w_any       = v_lo_found;
        w_arb_index = v_hi_found ? v_hi : v_lo;
    end

    // One-hot decode of the winner; all-zero when nothing is requested.
    always_comb begin
        w_arb_grant = '0;
        for (int i = 0; i < ENTRIES; i++) begin
            w_arb_grant[i] = w_any && (w_arb_index == INDEX_WIDTH'(i));
        end
    end

    // In HOLD the outputs come straight from flops; i_request is ignored.
    assign w_valid     = r_held | w_any;
    assign w_sel_index = r_held ? r_held_index : w_arb_index;
    assign w_sel_grant = r_held ? r_held_grant : w_arb_grant;

    // Pointer moves just past the winner, wrapping at ENTRIES rather than at
    // 2^INDEX_WIDTH so non-power-of-two sizes stay fair.
    assign w_next_ptr = (int'(w_sel_index) >= ENTRIES - 1) ? '0
                                                           : w_sel_index + INDEX_WIDTH'(1);

    // Outputs are forced low while reset is asserted, so an asynchronous reset
    // mid-transfer removes the grant at once even with requests still high.
    assign o_valid       = !i_rst && w_valid;
    assign o_grant       = i_rst ? '0 : w_sel_grant;
    assign o_grant_index = i_rst ? '0 : w_sel_index;

    // NOTE: state flops use non-blocking assignments so every register samples
    // the pre-edge values, independent of statement order.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_ptr        <= '0;
            r_held       <= 1'b0;
            r_held_grant <= '0;
            r_held_index <= '0;
        end else if (i_clear) begin
            // Clear beats a simultaneous ack.
            r_ptr  <= '0;
            r_held <= 1'b0;
        end else if (w_valid && i_ack) begin
            r_ptr  <= w_next_ptr;
            r_held <= 1'b0;
        end else if (w_valid && (KEEP_RESULT != 0) && !r_held) begin
            r_held       <= 1'b1;
            r_held_grant <= w_arb_grant;
            r_held_index <= w_arb_index;
        end
    end

endmodule

// File: tb/tb_std_rr_arbiter.sv
// -----------------------------------------------------------------------------
// tb_std_rr_arbiter
//
// Four arbiter instances share one clock and reset:
//   inst 0: ENTRIES=4, KEEP_RESULT=1
//   inst 1: ENTRIES=3, KEEP_RESULT=1  (non-power-of-two wrap)
//   inst 2: ENTRIES=4, KEEP_RESULT=0  (no hold)
//   inst 3: ENTRIES=1, KEEP_RESULT=1  (degenerate size)
// Inputs are driven on the falling edge and outputs sampled 1 ns later.
// -----------------------------------------------------------------------------
module tb_std_rr_arbiter;

    localparam int NE [4] = '{4, 3, 4, 1};
    localparam bit KR [4] = '{1'b1, 1'b1, 1'b0, 1'b1};

    logic clk;
    logic rst;

    logic [3:0] tb_req [4];
    logic       tb_ack [4];
    logic       tb_clr [4];

    logic [3:0] ob_grant [4];
    logic [1:0] ob_idx   [4];
    logic       ob_valid [4];

    logic       v_a, v_b, v_c, v_d;
    logic [3:0] g_a, g_c;
    logic [2:0] g_b;
    logic [0:0] g_d;
    logic [1:0] x_a, x_b, x_c;
    logic [0:0] x_d;

    int tests_run    = 0;
    int tests_failed = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    std_rr_arbiter #(.ENTRIES(4), .KEEP_RESULT(1)) u_a (
        .i_clk(clk), .i_rst(rst), .i_clear(tb_clr[0]), .i_request(tb_req[0]),
        .i_ack(tb_ack[0]), .o_valid(v_a), .o_grant(g_a), .o_grant_index(x_a)
    );
    std_rr_arbiter #(.ENTRIES(3), .KEEP_RESULT(1)) u_b (
        .i_clk(clk), .i_rst(rst), .i_clear(tb_clr[1]), .i_request(tb_req[1][2:0]),
        .i_ack(tb_ack[1]), .o_valid(v_b), .o_grant(g_b), .o_grant_index(x_b)
    );
    std_rr_arbiter #(.ENTRIES(4), .KEEP_RESULT(0)) u_c (
        .i_clk(clk), .i_rst(rst), .i_clear(tb_clr[2]), .i_request(tb_req[2]),
        .i_ack(tb_ack[2]), .o_valid(v_c), .o_grant(g_c), .o_grant_index(x_c)
    );
    std_rr_arbiter #(.ENTRIES(1), .KEEP_RESULT(1)) u_d (
        .i_clk(clk), .i_rst(rst), .i_clear(tb_clr[3]), .i_request(tb_req[3][0:0]),
        .i_ack(tb_ack[3]), .o_valid(v_d), .o_grant(g_d), .o_grant_index(x_d)
    );

    assign ob_valid[0] = v_a;  assign ob_grant[0] = g_a;           assign ob_idx[0] = x_a;
    assign ob_valid[1] = v_b;  assign ob_grant[1] = {1'b0, g_b};   assign ob_idx[1] = x_b;
    assign ob_valid[2] = v_c;  assign ob_grant[2] = g_c;           assign ob_idx[2] = x_c;
    assign ob_valid[3] = v_d;  assign ob_grant[3] = {3'b000, g_d}; assign ob_idx[3] = {1'b0, x_d};

    // Reference model: pointer as a plain integer, hold as a flag + index.
    typedef struct {
        int ptr;
        bit held;
        int hidx;
    } model_t;

    // First requester found walking ptr, ptr+1, ... modulo n; -1 if none.
    function automatic int model_winner(int n, int ptr, logic [3:0] req);
        for (int k = 0; k < n; k++) begin
            int j;
            j = (ptr + k) % n;
            if (req[j]) return j;
        end
        return -1;
    endfunction

    task automatic zero_inputs();
        for (int i = 0; i < 4; i++) begin
            tb_req[i] = 4'b0000;
            tb_ack[i] = 1'b0;
            tb_clr[i] = 1'b0;
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        zero_inputs();
        @(negedge clk);
        rst = 1'b0;
    endtask

    // Outputs must be zero during reset even with every request asserted.
    task automatic test_reset();
        rst = 1'b1;
        zero_inputs();
        for (int i = 0; i < 4; i++) tb_req[i] = 4'b1111;
        @(negedge clk);
        #1;
        for (int i = 0; i < 4; i++) begin
            tests_run++;
            if ({ob_valid[i], ob_grant[i], ob_idx[i]} !== 7'b0) begin
                tests_failed++;
                $display("FAIL reset inst%0d: got v=%b g=%b i=%0d, want v=0 g=0000 i=0",
                         i, ob_valid[i], ob_grant[i], ob_idx[i]);
            end
        end
        @(negedge clk);
        rst = 1'b0;
        zero_inputs();
    endtask

    // ENTRIES=4, requests 1010: grant 1, ack, grant 3, ack, wrap to 1.
    task automatic test_basic();
        logic [3:0] req_t [5] = '{4'b1010, 4'b1010, 4'b1010, 4'b1010, 4'b1010};
        logic       ack_t [5] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
        logic [3:0] gnt_t [5] = '{4'b0010, 4'b0010, 4'b1000, 4'b1000, 4'b0010};
        logic [1:0] idx_t [5] = '{2'd1, 2'd1, 2'd3, 2'd3, 2'd1};
        do_reset();
        for (int s = 0; s < 5; s++) begin
            @(negedge clk);
            tb_req[0] = req_t[s];
            tb_ack[0] = ack_t[s];
            #1;
            tests_run++;
            if ({ob_valid[0], ob_grant[0], ob_idx[0]} !== {1'b1, gnt_t[s], idx_t[s]}) begin
                tests_failed++;
                $display("FAIL basic step%0d: got v=%b g=%b i=%0d, want v=1 g=%b i=%0d",
                         s, ob_valid[0], ob_grant[0], ob_idx[0], gnt_t[s], idx_t[s]);
            end
        end
        zero_inputs();
    endtask

    // ENTRIES=3, all requests, ack every cycle: index 0,1,2,0,1,2.
    task automatic test_back_to_back();
        do_reset();
        for (int s = 0; s < 6; s++) begin
            logic [1:0] ei;
            @(negedge clk);
            tb_req[1] = 4'b0111;
            tb_ack[1] = 1'b1;
            #1;
            ei = 2'(s % 3);
            tests_run++;
            if ({ob_valid[1], ob_grant[1], ob_idx[1]} !== {1'b1, 4'(4'b0001 << ei), ei}) begin
                tests_failed++;
                $display("FAIL back_to_back step%0d: got v=%b g=%b i=%0d, want v=1 i=%0d",
                         s, ob_valid[1], ob_grant[1], ob_idx[1], ei);
            end
        end
        zero_inputs();
    endtask

    // KEEP_RESULT=1: grant 0100 stays through request change until ack.
    task automatic test_hold();
        logic [3:0] req_t [5] = '{4'b0100, 4'b0001, 4'b0001, 4'b0001, 4'b0001};
        logic       ack_t [5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        logic [3:0] gnt_t [5] = '{4'b0100, 4'b0100, 4'b0100, 4'b0100, 4'b0001};
        logic [1:0] idx_t [5] = '{2'd2, 2'd2, 2'd2, 2'd2, 2'd0};
        do_reset();
        for (int s = 0; s < 5; s++) begin
            @(negedge clk);
            tb_req[0] = req_t[s];
            tb_ack[0] = ack_t[s];
            #1;
            tests_run++;
            if ({ob_valid[0], ob_grant[0], ob_idx[0]} !== {1'b1, gnt_t[s], idx_t[s]}) begin
                tests_failed++;
                $display("FAIL hold step%0d: got v=%b g=%b i=%0d, want v=1 g=%b i=%0d",
                         s, ob_valid[0], ob_grant[0], ob_idx[0], gnt_t[s], idx_t[s]);
            end
        end
        zero_inputs();
    endtask

    // KEEP_RESULT=0: the grant follows requests at once; ptr moves only on ack.
    task automatic test_no_hold();
        logic [3:0] req_t [5] = '{4'b0100, 4'b0001, 4'b0001, 4'b0001, 4'b0101};
        logic       ack_t [5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        logic [3:0] gnt_t [5] = '{4'b0100, 4'b0001, 4'b0001, 4'b0001, 4'b0100};
        logic [1:0] idx_t [5] = '{2'd2, 2'd0, 2'd0, 2'd0, 2'd2};
        do_reset();
        for (int s = 0; s < 5; s++) begin
            @(negedge clk);
            tb_req[2] = req_t[s];
            tb_ack[2] = ack_t[s];
            #1;
            tests_run++;
            if ({ob_valid[2], ob_grant[2], ob_idx[2]} !== {1'b1, gnt_t[s], idx_t[s]}) begin
                tests_failed++;
                $display("FAIL no_hold step%0d: got v=%b g=%b i=%0d, want v=1 g=%b i=%0d",
                         s, ob_valid[2], ob_grant[2], ob_idx[2], gnt_t[s], idx_t[s]);
            end
        end
        zero_inputs();
    endtask

    // Pointer brought to 2, then clear and ack together: clear wins.
    task automatic test_clear_ack();
        logic [3:0] req_t [3] = '{4'b0010, 4'b1111, 4'b1111};
        logic       ack_t [3] = '{1'b1, 1'b1, 1'b0};
        logic       clr_t [3] = '{1'b0, 1'b1, 1'b0};
        logic [3:0] gnt_t [3] = '{4'b0010, 4'b0100, 4'b0001};
        logic [1:0] idx_t [3] = '{2'd1, 2'd2, 2'd0};
        do_reset();
        for (int s = 0; s < 3; s++) begin
            @(negedge clk);
            tb_req[0] = req_t[s];
            tb_ack[0] = ack_t[s];
            tb_clr[0] = clr_t[s];
            #1;
            tests_run++;
            if ({ob_valid[0], ob_grant[0], ob_idx[0]} !== {1'b1, gnt_t[s], idx_t[s]}) begin
                tests_failed++;
                $display("FAIL clear_ack step%0d: got v=%b g=%b i=%0d, want v=1 g=%b i=%0d",
                         s, ob_valid[0], ob_grant[0], ob_idx[0], gnt_t[s], idx_t[s]);
            end
        end
        zero_inputs();
    endtask

    // Reset asserted between edges while holding drops outputs at once.
    task automatic test_async_reset();
        do_reset();
        @(negedge clk);
        tb_req[0] = 4'b0100;
        @(negedge clk);
        tb_req[0] = 4'b1111;
        #1;
        tests_run++;
        if ({ob_valid[0], ob_grant[0], ob_idx[0]} !== {1'b1, 4'b0100, 2'd2}) begin
            tests_failed++;
            $display("FAIL async_reset held: got v=%b g=%b i=%0d, want v=1 g=0100 i=2",
                     ob_valid[0], ob_grant[0], ob_idx[0]);
        end
        #1;
        rst = 1'b1;
        #1;
        tests_run++;
        if ({ob_valid[0], ob_grant[0], ob_idx[0]} !== 7'b0) begin
            tests_failed++;
            $display("FAIL async_reset drop: got v=%b g=%b i=%0d, want v=0 g=0000 i=0",
                     ob_valid[0], ob_grant[0], ob_idx[0]);
        end
        @(negedge clk);
        rst = 1'b0;
        #1;
        tests_run++;
        if ({ob_valid[0], ob_grant[0], ob_idx[0]} !== {1'b1, 4'b0001, 2'd0}) begin
            tests_failed++;
            $display("FAIL async_reset release: got v=%b g=%b i=%0d, want v=1 g=0001 i=0",
                     ob_valid[0], ob_grant[0], ob_idx[0]);
        end
        zero_inputs();
    endtask

    // Random requests, acks and occasional clears on all instances.
    task automatic test_random();
        model_t m [4];
        do_reset();
        for (int i = 0; i < 4; i++) begin
            m[i].ptr  = 0;
            m[i].held = 1'b0;
            m[i].hidx = 0;
        end
        for (int c = 0; c < 500; c++) begin
            @(negedge clk);
            for (int i = 0; i < 4; i++) begin
                logic [3:0] mask;
                mask      = (4'b0001 << NE[i]) - 4'b0001;
                tb_req[i] = 4'($urandom) & mask;
                tb_ack[i] = 1'($urandom);
                tb_clr[i] = ($urandom_range(0, 15) == 0);
            end
            #1;
            for (int i = 0; i < 4; i++) begin
                int         w;
                bit         ev;
                int         ei;
                logic [3:0] eg;
                w  = model_winner(NE[i], m[i].ptr, tb_req[i]);
                ev = m[i].held || (w >= 0);
                ei = m[i].held ? m[i].hidx : ((w < 0) ? 0 : w);
                eg = ev ? (4'b0001 << ei) : 4'b0000;
                tests_run++;
                if ({ob_valid[i], ob_grant[i], ob_idx[i]} !== {ev, eg, 2'(ei)}) begin
                    tests_failed++;
                    $display("FAIL random inst%0d cyc%0d req=%b: got v=%b g=%b i=%0d, want v=%b g=%b i=%0d",
                             i, c, tb_req[i], ob_valid[i], ob_grant[i], ob_idx[i], ev, eg, ei);
                end
                if (tb_clr[i]) begin
                    m[i].ptr  = 0;
                    m[i].held = 1'b0;
                end else if (ev && tb_ack[i]) begin
                    m[i].ptr  = (ei + 1) % NE[i];
                    m[i].held = 1'b0;
                end else if (ev && KR[i] && !m[i].held) begin
                    m[i].held = 1'b1;
                    m[i].hidx = ei;
                end
            end
        end
        zero_inputs();
    endtask

    initial begin
        test_reset();
        test_basic();
        test_back_to_back();
        test_hold();
        test_no_hold();
        test_clear_ack();
        test_async_reset();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
